// File: rtl/eq_cfg_pkg.sv
// -----------------------------------------------------------------------------
// eq_cfg_pkg
// Shared definitions for the equalizer configuration controller:
//   - register addresses of the CTRL and STATUS registers
//   - bit positions inside CTRL and STATUS
//   - reset gain (1.0 in Q2.6)
//   - commit sequencer state encoding
//   - helper that sizes the band index
// -----------------------------------------------------------------------------
package eq_cfg_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h10;
    localparam logic [7:0] ADDR_STATUS = 8'h11;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_BYPASS_BIT = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_ERR_BIT  = 1;

    localparam logic [7:0] UNITY_GAIN_Q26 = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2,
        ST_DONE    = 2'd3
    } commit_state_t;

    // The band index needs clog2(n) bits, but never fewer than one.
    function automatic int band_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eq_commit_fsm.sv
// -----------------------------------------------------------------------------
// eq_commit_fsm
// Commit sequencer: waits for a frame boundary after a commit request, then
// walks the band index 0..NUM_BANDS-1 (one band per cycle), then announces the
// new bank for one cycle.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   commit_req   : accepted CTRL write with COMMIT=1 (only honoured in IDLE)
//   sample_tick  : frame-boundary pulse (only honoured in PENDING)
//   state        : current sequencer state (debug visibility)
//   busy         : high in PENDING, COPY and DONE
//   copy_idx     : band being copied this cycle (valid while in COPY)
//   copy_last    : high in the COPY cycle that handles the last band
//   cfg_update   : one-cycle pulse while in DONE
// -----------------------------------------------------------------------------
module eq_commit_fsm
    import eq_cfg_pkg::*;
#(
    parameter int NUM_BANDS = 8,
    parameter int IDX_W     = band_idx_width(NUM_BANDS)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             commit_req,
    input  logic             sample_tick,
    output commit_state_t    state,
    output logic             busy,
    output logic [IDX_W-1:0] copy_idx,
    output logic             copy_last,
    output logic             cfg_update
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

    commit_state_t    state_next;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx_q <= '0;
        end else begin
            state <= state_next;
            idx_q <= idx_next;
        end
    end

    // Next-state logic; the index wraps back to 0 after the last band so it
    // never runs past NUM_BANDS-1.
    always_comb begin
        state_next = state;
        idx_next   = idx_q;
        case (state)
            ST_IDLE: begin
                if (commit_req) state_next = ST_PENDING;
            end
            ST_PENDING: begin
                if (sample_tick) begin
                    state_next = ST_COPY;
                    idx_next   = '0;
                end
            end
            ST_COPY: begin
                if (idx_q == LAST_IDX) begin
                    state_next = ST_DONE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy       = (state != ST_IDLE);
        copy_idx   = idx_q;
        copy_last  = (state == ST_COPY) && (idx_q == LAST_IDX);
        cfg_update = (state == ST_DONE);
    end

endmodule

// File: rtl/eq_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// eq_cfg_ctrl
// Equalizer configuration controller. Holds a shadow gain bank written over
// the register interface and an active gain bank that drives the datapath.
// A commit copies shadow -> active band by band, starting on the frame
// boundary after the commit request, so the datapath never sees a half
// written bank mid-frame.
//
// Build option: define EQ_CFG_READBACK_EN to include the rd_addr/rd_data
// readback path; without it rd_data is tied to 8'h00.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en       : one-cycle write strobe; wr_addr/wr_data qualify it
//   rd_addr     : readback address; rd_data follows one cycle later
//   sample_tick : frame-boundary pulse
//   gain_bus    : active gains, band 0 in bits [7:0]
//   bypass      : active bypass flag
//   cfg_update  : one-cycle pulse when the active bank has changed
//   busy        : commit in progress
//   err         : sticky error (reserved address, or gain/CTRL write while busy)
//
// Register map: 0x00..NUM_BANDS-1 shadow gains, 0x10 CTRL
// (bit0 COMMIT self-clearing, bit1 BYPASS_SHADOW), 0x11 STATUS
// (bit0 busy, bit1 err; any write clears err). Everything else is reserved.
// -----------------------------------------------------------------------------
module eq_cfg_ctrl
    import eq_cfg_pkg::*;
#(
    parameter int         NUM_BANDS  = 8,
    parameter logic [7:0] UNITY_GAIN = UNITY_GAIN_Q26
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_addr,
    input  logic [7:0]             wr_data,
    input  logic [7:0]             rd_addr,
    output logic [7:0]             rd_data,
    input  logic                   sample_tick,
    output logic [NUM_BANDS*8-1:0] gain_bus,
    output logic                   bypass,
    output logic                   cfg_update,
    output logic                   busy,
    output logic                   err
);

    localparam int         IDX_W      = band_idx_width(NUM_BANDS);
    localparam logic [7:0] BAND_LIMIT = 8'(NUM_BANDS);

    logic [7:0]       shadow_gain [NUM_BANDS];
    logic [7:0]       active_gain [NUM_BANDS];
    logic             bypass_shadow;

    commit_state_t    fsm_state;
    logic [IDX_W-1:0] copy_idx;
    logic             copy_last;
    logic             copy_en;

    logic             hit_gain, hit_ctrl, hit_status, hit_reserved;
    logic             wr_gain, wr_ctrl, wr_drop, commit_req;
    logic [IDX_W-1:0] wr_idx;

    // Write decode. Gain and CTRL writes are locked out for the whole commit
    // so the bank being copied cannot change underneath the sequencer.
    assign hit_gain     = (wr_addr < BAND_LIMIT);
    assign hit_ctrl     = (wr_addr == ADDR_CTRL);
    assign hit_status   = (wr_addr == ADDR_STATUS);
    assign hit_reserved = !(hit_gain || hit_ctrl || hit_status);
    assign wr_gain      = wr_en && hit_gain && !busy;
    assign wr_ctrl      = wr_en && hit_ctrl && !busy;
    assign wr_drop      = wr_en && (hit_reserved || (busy && (hit_gain || hit_ctrl)));
    assign commit_req   = wr_ctrl && wr_data[CTRL_COMMIT_BIT];
    assign wr_idx       = wr_addr[IDX_W-1:0];
    assign copy_en      = (fsm_state == ST_COPY);

    eq_commit_fsm #(
        .NUM_BANDS (NUM_BANDS),
        .IDX_W     (IDX_W)
    ) u_commit_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .commit_req  (commit_req),
        .sample_tick (sample_tick),
        .state       (fsm_state),
        .busy        (busy),
        .copy_idx    (copy_idx),
        .copy_last   (copy_last),
        .cfg_update  (cfg_update)
    );

    // Shadow bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANDS; i++) shadow_gain[i] <= UNITY_GAIN;
        end else if (wr_gain) begin
            shadow_gain[wr_idx] <= wr_data;
        end
    end

    // Active bank: one band per COPY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANDS; i++) active_gain[i] <= UNITY_GAIN;
        end else if (copy_en) begin
            active_gain[copy_idx] <= shadow_gain[copy_idx];
        end
    end

    // CTRL, active bypass and sticky error. Bypass is loaded on the edge that
    // enters DONE so it becomes visible in the same cycle as cfg_update and
    // the last copied band.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypass_shadow <= 1'b0;
            bypass        <= 1'b0;
            err           <= 1'b0;
        end else begin
            if (wr_ctrl)   bypass_shadow <= wr_data[CTRL_BYPASS_BIT];
            if (copy_last) bypass        <= bypass_shadow;
            if (wr_drop)                      err <= 1'b1;
            else if (wr_en && hit_status)     err <= 1'b0;
        end
    end

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_gain_bus
        assign gain_bus[b*8 +: 8] = active_gain[b];
    end

`ifdef EQ_CFG_READBACK_EN
    logic [7:0] rd_mux;

    // COMMIT is self-clearing, so CTRL reads back with bit0 always 0.
    always_comb begin
        rd_mux = 8'h00;
        if (rd_addr < BAND_LIMIT) begin
            rd_mux = shadow_gain[rd_addr[IDX_W-1:0]];
        end else if (rd_addr == ADDR_CTRL) begin
            rd_mux[CTRL_BYPASS_BIT] = bypass_shadow;
        end else if (rd_addr == ADDR_STATUS) begin
            rd_mux[STATUS_BUSY_BIT] = busy;
            rd_mux[STATUS_ERR_BIT]  = err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= 8'h00;
        else        rd_data <= rd_mux;
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = 8'h00;
`endif

endmodule

// File: tb/tb_eq_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eq_cfg_ctrl
// Directed bench for eq_cfg_ctrl (NUM_BANDS = 8). Each commit that should
// produce a cfg_update pushes {expected cycle, bypass, gains} into exp_q; the
// monitor pops one entry per cfg_update cycle. Register-side effects (err,
// busy, readback) are checked directly after each write.
// -----------------------------------------------------------------------------
module tb_eq_cfg_ctrl;

    localparam int NB = 8;
    localparam logic [63:0] ALL_UNITY = {8{8'h40}};
    localparam logic [63:0] G1 = 64'h7F40_4040_4040_4020;  // band0=20, band7=7F
    localparam logic [63:0] G2 = 64'h7F40_3340_4040_4020;  // G1 plus band5=33

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic           wr_en = 1'b0;
    logic [7:0]     wr_addr = 8'h00;
    logic [7:0]     wr_data = 8'h00;
    logic [7:0]     rd_addr = 8'h00;
    logic [7:0]     rd_data;
    logic           sample_tick = 1'b0;
    logic [NB*8-1:0] gain_bus;
    logic           bypass, cfg_update, busy, err;

    eq_cfg_ctrl #(
        .NUM_BANDS  (NB),
        .UNITY_GAIN (8'h40)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .sample_tick (sample_tick),
        .gain_bus    (gain_bus),
        .bypass      (bypass),
        .cfg_update  (cfg_update),
        .busy        (busy),
        .err         (err)
    );

    // ---------------- scoreboard ----------------
    int checks_total  = 0;
    int checks_passed = 0;
    int pulses        = 0;
    logic [96:0] exp_q[$];   // {cycle[31:0], bypass, gains[63:0]}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin : monitor
        logic [96:0] e;
        if (rst_n && cfg_update) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks_total++;
                $display("FAIL unexpected_cfg_update: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                check("commit_gain", gain_bus, e[63:0]);
                check("commit_bypass", {63'b0, bypass}, {63'b0, e[64]});
                check("commit_latency", 64'(cyc), 64'(e[96:65]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Tick sampled at the next edge; cfg_update is expected 9 cycles later.
    task automatic tick(input bit expect_commit, input logic [63:0] g, input logic b);
        @(posedge clk); #1;
        sample_tick = 1'b1;
        if (expect_commit) exp_q.push_back({32'(cyc + 9), b, g});
        @(posedge clk); #1;
        sample_tick = 1'b0;
    endtask

    task automatic wr_tick(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d; sample_tick = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; sample_tick = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        rd_addr = a;
        @(posedge clk); #1;
        d = rd_data;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", {63'b0, busy}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] r;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gain", gain_bus, ALL_UNITY);
        check("rst_bypass", {63'b0, bypass}, 64'd0);
        check("rst_err", {63'b0, err}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_cfg_update", {63'b0, cfg_update}, 64'd0);
        check("rst_rd_data", {56'b0, rd_data}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_gain", gain_bus, ALL_UNITY);
        check("post_rst_bypass", {63'b0, bypass}, 64'd0);
        check("post_rst_err", {63'b0, err}, 64'd0);

        // Basic commit with bypass
        wr(8'h00, 8'h20);
        wr(8'h07, 8'h7F);
        wr(8'h10, 8'h03);
        check("pending_busy", {63'b0, busy}, 64'd1);
        check("pending_gain_unchanged", gain_bus, ALL_UNITY);
        tick(1'b1, G1, 1'b1);
        wait_idle();
        check("commit1_err", {63'b0, err}, 64'd0);
`ifdef EQ_CFG_READBACK_EN
        rd(8'h00, r); check("rd_band0", {56'b0, r}, 64'h20);
        rd(8'h10, r); check("rd_ctrl", {56'b0, r}, 64'h02);
        rd(8'h11, r); check("rd_status", {56'b0, r}, 64'h00);
`endif

        // Tick while idle does nothing
        tick(1'b0, 64'd0, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("idle_tick_busy", {63'b0, busy}, 64'd0);

        // Writes while busy are dropped; STATUS still clears err
        wr(8'h10, 8'h01);
        wr(8'h03, 8'h10);
        check("busy_gain_err", {63'b0, err}, 64'd1);
        wr(8'h11, 8'h00);
        check("status_clear_busy", {63'b0, err}, 64'd0);
        check("still_busy", {63'b0, busy}, 64'd1);
        wr(8'h10, 8'h02);
        check("busy_ctrl_err", {63'b0, err}, 64'd1);
        tick(1'b1, G1, 1'b0);
        tick(1'b0, 64'd0, 1'b0);   // lands during COPY
        wait_idle();
        wr(8'h11, 8'hFF);
        check("status_clear", {63'b0, err}, 64'd0);

        // Reserved addresses
        wr(8'h2A, 8'h55);
        check("reserved_err", {63'b0, err}, 64'd1);
        check("reserved_gain", gain_bus, G1);
        rd(8'h2A, r);
        check("reserved_rd", {56'b0, r}, 64'h00);
        wr(8'h11, 8'h00);
        wr(8'h08, 8'h01);
        check("reserved_08_err", {63'b0, err}, 64'd1);
        wr(8'h11, 8'h00);
        check("reserved_clear", {63'b0, err}, 64'd0);

        // Commit and tick in the same cycle: wait for the next tick
        wr(8'h05, 8'h33);
        wr_tick(8'h10, 8'h03);
        repeat (12) @(posedge clk);
        #1;
        check("same_cycle_pending", {63'b0, busy}, 64'd1);
        check("same_cycle_no_copy", gain_bus, G1);
        tick(1'b1, G2, 1'b1);
        wait_idle();

        // Reset during COPY at band 4 aborts the commit
        wr(8'h01, 8'h11);
        wr(8'h10, 8'h01);
        tick(1'b0, 64'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("mid_copy_band1", {56'b0, gain_bus[15:8]}, 64'h11);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("abort_gain", gain_bus, ALL_UNITY);
        check("abort_bypass", {63'b0, bypass}, 64'd0);
        check("abort_busy", {63'b0, busy}, 64'd0);

        // Final scoreboard state
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("pulse_count", 64'(pulses), 64'd3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
